// File: rtl/i2c_command_scheduler.sv
// I2C command scheduler: pops commands from a first-word-fall-through queue, runs them on the
// I2C controller and forwards read data (or 8'hEE on error) to the UART. `SCHED_POLL_EN adds periodic temperature polling.
module i2c_command_scheduler #(
    parameter int unsigned POLL_CYCLES  = 100000000,
    parameter int unsigned WAIT_TIMEOUT = 1000000,
    parameter logic [7:0]  TEMP_PTR     = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        queue_empty,
    input  logic [7:0]  q_addr,
    input  logic [2:0]  q_mode,
    input  logic [15:0] q_data,
    output logic        rd_queue,
    input  logic        i2c_ready,
    input  logic        i2c_done,
    input  logic        i2c_ack_error,
    input  logic [15:0] i2c_rd_data,
    output logic        i2c_start,
    output logic [2:0]  i2c_mode,
    output logic [7:0]  i2c_addr,
    output logic [15:0] i2c_wr_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done_tick,
    output logic [15:0] temperature,
    output logic        temp_valid,
    output logic        cmd_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        TX_HI  = 3'd3,
        TX_LO  = 3'd4,
        TX_ERR = 3'd5
    } state_t;

    localparam logic [19:0] WAIT_LAST = 20'(WAIT_TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [19:0] wait_cnt_r;
    logic        is_poll_r;
    logic        tx_sent_r;
    logic [15:0] rd_data_r, rd_src_s;
    logic [7:0]  i2c_addr_r, tx_data_r;
    logic [2:0]  i2c_mode_r;
    logic [15:0] i2c_wr_data_r, temperature_r;
    logic        temp_valid_r;
    logic        rd_queue_s, start_s, tx_start_s, cmd_error_s;
    logic        load_cmd_s, load_poll_s, capture_s;
    logic        poll_pending_s;

`ifdef SCHED_POLL_EN
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

    logic [PW-1:0] poll_cnt_r;
    logic          poll_pending_r;

    // Free-running poll timer; a pending poll is held until IDLE takes it, extra expiries are absorbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt_r     <= '0;
            poll_pending_r <= 1'b0;
        end else begin
            poll_cnt_r     <= (poll_cnt_r == POLL_LAST) ? '0 : poll_cnt_r + PW'(1);
            poll_pending_r <= (poll_cnt_r == POLL_LAST) | (poll_pending_r & ~load_poll_s);
        end
    end

    assign poll_pending_s = poll_pending_r;
`else
    logic [31:0] unused_poll_cfg_s;
    assign unused_poll_cfg_s = 32'(POLL_CYCLES);
    assign poll_pending_s    = 1'b0;
`endif

    // Next-state and single-cycle pulse decode.
    always_comb begin
        state_s     = state_r;
        rd_queue_s  = 1'b0;
        start_s     = 1'b0;
        tx_start_s  = 1'b0;
        cmd_error_s = 1'b0;
        load_cmd_s  = 1'b0;
        load_poll_s = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!queue_empty) begin
                    rd_queue_s = 1'b1;
                    load_cmd_s = 1'b1;
                    if (q_mode > 3'd4) begin
                        cmd_error_s = 1'b1;
                        state_s     = TX_ERR;
                    end else begin
                        state_s = ISSUE;
                    end
                end else if (poll_pending_s) begin
                    load_poll_s = 1'b1;
                    state_s     = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (i2c_ready) begin
                    start_s = 1'b1;
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                // i2c_done takes precedence over a timeout in the same cycle
                if (i2c_done) begin
                    capture_s = 1'b1;
                    if (i2c_ack_error) begin
                        cmd_error_s = 1'b1;
                        state_s     = is_poll_r ? IDLE : TX_ERR;
                    end else if (is_poll_r) begin
                        state_s = IDLE;
                    end else if (i2c_mode_r == 3'b100) begin
                        state_s = TX_HI;
                    end else if (i2c_mode_r == 3'b001) begin
                        state_s = TX_LO;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    cmd_error_s = 1'b1;
                    state_s     = is_poll_r ? IDLE : TX_ERR;
                end else begin
                    state_s = WAIT;
                end
            end
            TX_HI, TX_LO, TX_ERR: begin
                tx_start_s = ~tx_sent_r;
                if (tx_sent_r && tx_done_tick) begin
                    state_s = (state_r == TX_HI) ? TX_LO : IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign rd_src_s = capture_s ? i2c_rd_data : rd_data_r;

    // State, counters and latched transaction/result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            wait_cnt_r    <= 20'd0;
            is_poll_r     <= 1'b0;
            tx_sent_r     <= 1'b0;
            rd_data_r     <= 16'h0000;
            i2c_addr_r    <= 8'h00;
            i2c_mode_r    <= 3'b000;
            i2c_wr_data_r <= 16'h0000;
            tx_data_r     <= 8'h00;
            temperature_r <= 16'h0000;
            temp_valid_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= (state_r == WAIT) ? wait_cnt_r + 20'd1 : 20'd0;
            tx_sent_r  <= (state_s == state_r) & (tx_sent_r | tx_start_s);
            if (load_cmd_s) begin
                i2c_addr_r    <= q_addr;
                i2c_mode_r    <= q_mode;
                i2c_wr_data_r <= q_data;
                is_poll_r     <= 1'b0;
            end else if (load_poll_s) begin
                i2c_addr_r <= TEMP_PTR;
                i2c_mode_r <= 3'b100;
                is_poll_r  <= 1'b1;
            end else begin
                is_poll_r <= is_poll_r;
            end
            if (capture_s) begin
                rd_data_r <= i2c_rd_data;
            end else begin
                rd_data_r <= rd_data_r;
            end
            if (capture_s && is_poll_r && !i2c_ack_error) begin
                temperature_r <= i2c_rd_data;
                temp_valid_r  <= 1'b1;
            end else begin
                temp_valid_r <= temp_valid_r;
            end
            case (state_s)
                TX_HI:   tx_data_r <= rd_src_s[15:8];
                TX_LO:   tx_data_r <= rd_src_s[7:0];
                TX_ERR:  tx_data_r <= 8'hEE;
                default: tx_data_r <= 8'h00;
            endcase
        end
    end

    // Pulses are masked during reset so every output reads 0 while it is held.
    assign rd_queue    = rd_queue_s & ~reset;
    assign i2c_start   = start_s & ~reset;
    assign tx_start    = tx_start_s & ~reset;
    assign cmd_error   = cmd_error_s & ~reset;
    assign i2c_addr    = i2c_addr_r;
    assign i2c_mode    = i2c_mode_r;
    assign i2c_wr_data = i2c_wr_data_r;
    assign tx_data     = tx_data_r;
    assign temperature = temperature_r;
    assign temp_valid  = temp_valid_r;

endmodule

// File: tb/tb_i2c_command_scheduler.sv
// Randomized bench for i2c_command_scheduler: models the queue, I2C controller and UART, and
// predicts pulses, bytes and temperature from a transaction-level reference model.
module tb_i2c_command_scheduler;
    localparam int WAIT_TO = 8;
    localparam int POLL_N  = 16;
    localparam int NCYC    = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        queue_empty;
    logic [7:0]  q_addr;
    logic [2:0]  q_mode;
    logic [15:0] q_data;
    logic        rd_queue;
    logic        i2c_ready, i2c_done, i2c_ack_error;
    logic [15:0] i2c_rd_data;
    logic        i2c_start;
    logic [2:0]  i2c_mode;
    logic [7:0]  i2c_addr;
    logic [15:0] i2c_wr_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done_tick;
    logic [15:0] temperature;
    logic        temp_valid;
    logic        cmd_error;

    always #5 clk = ~clk;

    i2c_command_scheduler #(
        .POLL_CYCLES (POLL_N),
        .WAIT_TIMEOUT(WAIT_TO),
        .TEMP_PTR    (8'h00)
    ) dut (
        .clk(clk), .reset(reset), .queue_empty(queue_empty), .q_addr(q_addr), .q_mode(q_mode),
        .q_data(q_data), .rd_queue(rd_queue), .i2c_ready(i2c_ready), .i2c_done(i2c_done),
        .i2c_ack_error(i2c_ack_error), .i2c_rd_data(i2c_rd_data), .i2c_start(i2c_start),
        .i2c_mode(i2c_mode), .i2c_addr(i2c_addr), .i2c_wr_data(i2c_wr_data), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done_tick(tx_done_tick), .temperature(temperature),
        .temp_valid(temp_valid), .cmd_error(cmd_error)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [2:0]  mode;
        logic [15:0] data;
    } cmd_t;

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_rd_queue"}, 32'(rd_queue), 32'd0);
        chk_eq({tag, "_i2c_start"}, 32'(i2c_start), 32'd0);
        chk_eq({tag, "_i2c_addr"}, 32'(i2c_addr), 32'd0);
        chk_eq({tag, "_i2c_mode"}, 32'(i2c_mode), 32'd0);
        chk_eq({tag, "_i2c_wr_data"}, 32'(i2c_wr_data), 32'd0);
        chk_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk_eq({tag, "_temperature"}, 32'(temperature), 32'd0);
        chk_eq({tag, "_temp_valid"}, 32'(temp_valid), 32'd0);
        chk_eq({tag, "_cmd_error"}, 32'(cmd_error), 32'd0);
    endtask

    // reference model state
    cmd_t        q[$];
    logic [7:0]  bytes[$];
    cmd_t        cur, nc;
    logic        busy, cur_poll, pend, take, pop_pending, tx_out, ack_plan, fin, upd_temp;
    logic        exp_rd, exp_st, exp_tx, exp_err, tv_exp, stray_done;
    logic [15:0] temp_exp, temp_next;
    int          ph, wait_n, done_at, tick_cnt, cyc, n_resets;

    task automatic model_reset();
        busy = 1'b0; ph = 0; cur_poll = 1'b0; pend = 1'b0; tx_out = 1'b0;
        bytes.delete(); temp_exp = 16'h0000; tv_exp = 1'b0; cyc = 0; pop_pending = 1'b0;
        wait_n = 0; done_at = 0; tick_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; queue_empty = 1'b1; q_addr = 8'h00; q_mode = 3'b000; q_data = 16'h0000;
        i2c_ready = 1'b0; i2c_done = 1'b0; i2c_ack_error = 1'b0; i2c_rd_data = 16'h0000;
        tx_done_tick = 1'b0; n_resets = 0; stray_done = 1'b0;
        cur = '0; ack_plan = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int n = 0; n < NCYC; n++) begin
            // mid-transaction reset: entry is lost, stray i2c_done must be ignored
            if (ph == 2 && n_resets < 6 && $urandom_range(0, 29) == 0) begin
                n_resets++;
                reset = 1'b1; i2c_done = 1'b1; i2c_ack_error = 1'b0;
                @(negedge clk);
                @(posedge clk); #1;
                @(negedge clk);
                chk_all_zero("mid_reset");
                @(posedge clk); #1;
                reset = 1'b0;
                model_reset();
                stray_done = 1'b1;
            end

            // drive inputs for this cycle
            if (pop_pending) begin
                void'(q.pop_front());
                pop_pending = 1'b0;
            end
            if (q.size() < 4 && $urandom_range(0, 3) == 0) begin
                nc.addr = 8'($urandom_range(1, 255));
                nc.mode = 3'($urandom_range(0, 7));
                nc.data = 16'($urandom);
                q.push_back(nc);
            end
            queue_empty = (q.size() == 0);
            if (q.size() > 0) begin
                q_addr = q[0].addr; q_mode = q[0].mode; q_data = q[0].data;
            end else begin
                q_addr = 8'h00; q_mode = 3'b000; q_data = 16'h0000;
            end
            i2c_ready     = ($urandom_range(0, 3) != 0);
            i2c_rd_data   = 16'($urandom);
            i2c_done      = stray_done || (ph == 2 && wait_n + 1 == done_at);
            i2c_ack_error = (ph == 2 && wait_n + 1 == done_at) ? ack_plan : 1'($urandom_range(0, 1));
            stray_done    = 1'b0;
            tx_done_tick  = 1'b0;
            if (tx_out) begin
                tick_cnt--;
                tx_done_tick = (tick_cnt == 0);
            end

            @(negedge clk);
            exp_rd = 1'b0; exp_st = 1'b0; exp_tx = 1'b0; exp_err = 1'b0;
            fin = 1'b0; take = 1'b0; upd_temp = 1'b0; temp_next = temp_exp;
            if (!busy) begin
                if (q.size() > 0) begin
                    exp_rd = 1'b1; pop_pending = 1'b1; cur = q[0]; cur_poll = 1'b0; busy = 1'b1;
                    if (cur.mode > 3'd4) begin
                        exp_err = 1'b1; bytes.push_back(8'hEE); ph = 3;
                    end else begin
                        ph = 1;
                    end
                end else if (pend) begin
                    take = 1'b1; cur_poll = 1'b1; cur.addr = 8'h00; cur.mode = 3'b100;
                    busy = 1'b1; ph = 1;
                end
            end else if (ph == 1) begin
                if (i2c_ready) begin
                    exp_st = 1'b1;
                    chk_eq("issue_addr", 32'(i2c_addr), 32'(cur.addr));
                    chk_eq("issue_mode", 32'(i2c_mode), 32'(cur.mode));
                    if (!cur_poll) chk_eq("issue_wr_data", 32'(i2c_wr_data), 32'(cur.data));
                    ph = 2; wait_n = 0;
                    done_at  = ($urandom_range(0, 8) == 0) ? 0 : $urandom_range(1, WAIT_TO);
                    ack_plan = ($urandom_range(0, 6) == 0);
                end
            end else if (ph == 2) begin
                wait_n++;
                chk_eq("wait_addr_stable", 32'(i2c_addr), 32'(cur.addr));
                chk_eq("wait_mode_stable", 32'(i2c_mode), 32'(cur.mode));
                if (i2c_done) begin
                    if (i2c_ack_error) begin
                        exp_err = 1'b1;
                        if (cur_poll) fin = 1'b1;
                        else begin bytes.push_back(8'hEE); ph = 3; end
                    end else if (cur_poll) begin
                        upd_temp = 1'b1; temp_next = i2c_rd_data; fin = 1'b1;
                    end else if (cur.mode == 3'b100) begin
                        bytes.push_back(i2c_rd_data[15:8]); bytes.push_back(i2c_rd_data[7:0]); ph = 3;
                    end else if (cur.mode == 3'b001) begin
                        bytes.push_back(i2c_rd_data[7:0]); ph = 3;
                    end else begin
                        fin = 1'b1;
                    end
                end else if (wait_n == WAIT_TO) begin
                    exp_err = 1'b1;
                    if (cur_poll) fin = 1'b1;
                    else begin bytes.push_back(8'hEE); ph = 3; end
                end
            end else if (ph == 3) begin
                if (!tx_out) begin
                    exp_tx = 1'b1;
                    chk_eq("tx_byte", 32'(tx_data), 32'(bytes[0]));
                    tx_out = 1'b1; tick_cnt = $urandom_range(1, 3);
                end else if (tx_done_tick) begin
                    chk_eq("tx_byte_held", 32'(tx_data), 32'(bytes[0]));
                    void'(bytes.pop_front());
                    tx_out = 1'b0;
                    if (bytes.size() == 0) fin = 1'b1;
                end
            end
            chk_eq("rd_queue", 32'(rd_queue), 32'(exp_rd));
            chk_eq("i2c_start", 32'(i2c_start), 32'(exp_st));
            chk_eq("tx_start", 32'(tx_start), 32'(exp_tx));
            chk_eq("cmd_error", 32'(cmd_error), 32'(exp_err));
            chk_eq("temperature", 32'(temperature), 32'(temp_exp));
            chk_eq("temp_valid", 32'(temp_valid), 32'(tv_exp));
            if (upd_temp) begin
                temp_exp = temp_next; tv_exp = 1'b1;
            end
            if (fin) begin
                busy = 1'b0; ph = 0;
            end
`ifdef SCHED_POLL_EN
            pend = ((cyc % POLL_N) == POLL_N - 1) || (pend && !take);
`endif
            cyc++;
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_command_scheduler.md
I2C_COMMAND_SCHEDULER -- requirements
Module: i2c_command_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- POLL_CYCLES, 100000000, clocks between automatic temperature polls (1 s at 100 MHz).
- WAIT_TIMEOUT, 1000000, maximum clocks to wait for i2c_done.
- TEMP_PTR, 8'h00, register pointer of the temperature register.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- queue_empty  in  1  instruction queue has no entry.
- q_addr  in  8  head entry: register pointer.
- q_mode  in  3  head entry: operation.
- q_data  in  16  head entry: write data; [7:0] is the first byte.
- rd_queue  out  1  pop head entry.
- i2c_ready  in  1  I2C controller idle.
- i2c_done  in  1  transaction-complete pulse.
- i2c_ack_error  in  1  NACK flag, valid with i2c_done.
- i2c_rd_data  in  16  read data, valid with i2c_done; [15:8] is the MSB.
- i2c_start  out  1  transaction start pulse.
- i2c_mode  out  3  operation for the I2C controller.
- i2c_addr  out  8  register pointer for the I2C controller.
- i2c_wr_data  out  16  write data for the I2C controller.
- tx_start  out  1  UART transmit request.
- tx_data  out  8  UART transmit byte.
- tx_done_tick  in  1  UART byte sent.
- temperature  out  16  last polled temperature.
- temp_valid  out  1  temperature has been updated at least once.
- cmd_error  out  1  one-cycle error pulse.

Function
REQ-004 Mode encoding SHALL be:
- 000: pointer write.
- 001: read 1 byte.
- 010: write 1 byte.
- 011: write 2 bytes.
- 100: read 2 bytes.
- 101-111: illegal.
REQ-005 The FSM states SHALL be IDLE, ISSUE, WAIT, TX_HI, TX_LO, TX_ERR.
REQ-006 In IDLE with !queue_empty, the block SHALL pulse rd_queue for one cycle, latch q_addr/q_mode/q_data into i2c_addr/i2c_mode/i2c_wr_data (first-word-fall-through queue), and go to ISSUE.
REQ-007 In IDLE with queue_empty and poll_pending, the block SHALL load i2c_addr=TEMP_PTR and i2c_mode=100, mark the transaction as a poll, clear poll_pending, and go to ISSUE.
REQ-008 A queued command SHALL take priority over a pending poll when both are present in the same cycle.
REQ-009 A popped entry with an illegal mode SHALL skip the I2C transaction, pulse cmd_error, and go to TX_ERR.
REQ-010 In ISSUE, the block SHALL pulse i2c_start for exactly one cycle in the first cycle that i2c_ready=1, then enter WAIT; while i2c_ready=0 it SHALL hold in ISSUE.
REQ-011 i2c_mode, i2c_addr and i2c_wr_data SHALL stay stable from ISSUE entry until WAIT exits.
REQ-012 In WAIT, a 20-bit counter SHALL run.
- Timeout: if the count reaches WAIT_TIMEOUT-1 before i2c_done, the block SHALL pulse cmd_error and go to TX_ERR (command) or IDLE (poll).
- Simultaneous: i2c_done arriving on the timeout cycle SHALL win.
REQ-013 On i2c_done with i2c_ack_error=1:
- Command: pulse cmd_error and go to TX_ERR.
- Poll: pulse cmd_error, go to IDLE, and leave temperature unchanged.
REQ-014 On a successful poll, the block SHALL latch temperature=i2c_rd_data, set temp_valid=1, and go to IDLE; nothing is transmitted.
REQ-015 On a successful command, the block SHALL go to:
- TX_HI for mode 100;
- TX_LO for mode 001;
- IDLE for write modes.
REQ-016 UART byte sequencing:
- TX_HI SHALL send i2c_rd_data[15:8], then go to TX_LO.
- TX_LO SHALL send i2c_rd_data[7:0].
- TX_ERR SHALL send 8'hEE.
- Each byte SHALL be sent as a one-cycle tx_start with tx_data held until tx_done_tick.
- After the last byte, the block SHALL return to IDLE.
REQ-017 The poll timer SHALL be free-running modulo POLL_CYCLES.
- Expiry SHALL set poll_pending.
- Expiry while poll_pending is already set SHALL be absorbed (at most one pending poll).
- Expiry during an active transaction SHALL be serviced after return to IDLE.
REQ-018 rd_queue SHALL never assert while queue_empty=1 or outside IDLE.

Reset
REQ-019 On reset, the block SHALL:
- set the state to IDLE;
- clear all counters and poll_pending;
- drive every output to 0, including temperature and temp_valid.
REQ-020 Reset mid-transaction SHALL abandon the transaction; the popped entry is lost and no tx_start follows.

Configuration
REQ-021 With SCHED_POLL_EN defined, the poll timer and polling behaviour SHALL be present.
REQ-022 Without SCHED_POLL_EN, the poll timer SHALL be removed, poll_pending SHALL be constant 0, and temperature and temp_valid SHALL stay 0.

Verification
REQ-023 Queue entry {addr=01, mode=010, data=0x0060}, i2c_ready=1 -> one rd_queue pulse; i2c_start one cycle later with i2c_addr=01, i2c_wr_data=0x0060; no tx_start after i2c_done.
REQ-024 Entry mode=100 and i2c_rd_data=0x1A80 returned -> tx_data 0x1A then 0x80, each gated by tx_done_tick.
REQ-025 SCHED_POLL_EN defined, POLL_CYCLES=16, empty queue, i2c_rd_data=0x0C10 -> poll issued with i2c_addr=00, i2c_mode=100; temperature=0x0C10, temp_valid=1; no tx.
REQ-026 Poll expiry and queue non-empty in the same cycle -> command issued first, poll issued immediately after the command completes.
REQ-027 i2c_done with i2c_ack_error=1 on a command -> cmd_error pulse, tx_data=0xEE; with WAIT_TIMEOUT=8 and no i2c_done -> cmd_error at the 8th WAIT cycle.
REQ-028 Reset asserted in WAIT -> all outputs 0 next cycle; a subsequent i2c_done is ignored.
